interboard_tx_scheduler: RTL and testbench
==========================================

Name: interboard_tx_scheduler

Overview:
Shares the single interboard transmit channel (transmit / ctrl_en / ctrl_msg_type / ctrl_number into InterboardCommunication_top) between several game-side requesters (e.g. game FSM, guess handler, win/restart announcer). Round-robin arbitration, one message in flight, completion detected from inter_ready, timeout with bounded retry. Sits between the game logic and InterboardCommunication_top on both master and slave boards.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT, 1024, cycles from issue until the transfer is declared lost (>=4)
MAX_RETRY, 2, re-issues after the first attempt before reporting error (0..7)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
interboard_rst  in  1  link-level restart from InterboardCommunication_top; synchronous abort
req_valid  in  NUM_REQ  per-requester request; held high with stable payload until done/err for that requester
req_msg_type  in  3*NUM_REQ  packed; requester i at [3i+2:3i]
req_number  in  5*NUM_REQ  packed; requester i at [5i+4:5i]
grant  out  NUM_REQ  one-hot; high while requester i is being serviced
done  out  NUM_REQ  one-cycle one-hot pulse: requester i's message delivered
err  out  NUM_REQ  one-cycle one-hot pulse: requester i's message failed after all retries
inter_ready  in  1  channel idle/ready from InterboardCommunication_top
transmit  out  1  one-cycle start pulse to the channel
ctrl_en  out  1  payload valid, asserted with transmit
ctrl_msg_type  out  3  latched message type
ctrl_number  out  5  latched number
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; grant, done, err, transmit, ctrl_en, busy = 0; ctrl_msg_type = 0; ctrl_number = 0; retry count 0; rr pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT_ACC, WAIT_CMP, FINISH.
- IDLE: when inter_ready=1 and any req_valid bit is set, select the first set bit searching from rr_ptr+1 upward with wrap. Latch the index and payload into ctrl_msg_type/ctrl_number, set grant[idx], go to ISSUE. Clear the timer and the retry count. If inter_ready=0, wait; no grant is issued.
- ISSUE (exactly 1 cycle): transmit=1 and ctrl_en=1 with the latched payload. Go to WAIT_ACC. Timer starts at 0 in the following cycle.
- WAIT_ACC: wait for inter_ready=0 (channel accepted). Then go to WAIT_CMP; the timer keeps running.
- WAIT_CMP: wait for inter_ready=1 (transfer complete). Then go to FINISH with success.
- Timer: increments every cycle in WAIT_ACC/WAIT_CMP and saturates. Width is clog2(TIMEOUT+1).
- Timeout: the timer reaches TIMEOUT-1 without completion.
  - If retries < MAX_RETRY: increment retries, clear the timer, go to ISSUE (same payload, grant held).
  - Otherwise: go to FINISH with failure.
- Timeout and completion in the same cycle: completion wins.
- FINISH (1 cycle): pulse done[idx] (success) or err[idx] (failure), drop grant, rr_ptr <= idx, go to IDLE. A new grant can be issued at the earliest in the cycle after FINISH. A requester whose req_valid is still high in IDLE is treated as a new request.
- Requester dropping req_valid mid-service is ignored: the transaction completes and done/err still pulses. Payload changes after latch are ignored.
- interboard_rst=1 (synchronous, highest priority over all transitions): go to IDLE and clear grant, transmit, ctrl_en, timer and retries. No done/err pulse. rr_ptr and the latched payload are kept.
- Fairness: with all NUM_REQ requesting continuously, each is served exactly once per NUM_REQ transactions.
- Outputs are registered; done/err/transmit are never high for more than 1 consecutive cycle. Exception: transmit re-pulses on retry.

Test Plan:
- Single request: req_valid=3'b010, type=3'd2, number=5'd17; channel drops inter_ready 2 cycles after transmit and raises it 10 cycles later. Required: transmit pulses once with ctrl_msg_type=2, ctrl_number=17; grant=3'b010 throughout; done=3'b010 for one cycle; busy then returns to 0.
- Round-robin: req_valid=3'b111 held, well-behaved channel. Required: grant order is 0,1,2,0 and done pulses match that order.
- Retry: channel ignores the first transmit, TIMEOUT=16, MAX_RETRY=2. Required: a second transmit 16 cycles after the first wait began, with the same payload; a normal ack then yields done, no err.
- Exhausted retries: channel never drops inter_ready, MAX_RETRY=2. Required: exactly 3 transmit pulses, then err[idx] for 1 cycle, no done; the next requester is served afterwards.
- Abort: assert interboard_rst in WAIT_CMP. Required: next cycle state IDLE, grant=0, no done/err pulse; a still-held request is re-issued after interboard_rst drops.
- Reset: assert rst low mid-ISSUE. Required: transmit, ctrl_en and grant are 0 immediately (async). After release with req_valid=3'b101, requester 0 is granted first.

Source files
------------

// File: rtl/interboard_tx_scheduler_if.sv
// Requester and channel bundle for the interboard transmit scheduler.
// master: scheduler side; slave: requesters plus InterboardCommunication_top side.
//   req_valid/req_msg_type/req_number : packed per-requester requests
//   grant/done/err                    : one-hot service, success and failure
//   inter_ready                       : channel idle/ready
//   transmit/ctrl_en/ctrl_*           : start pulse and latched payload
interface interboard_tx_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [3*NUM_REQ-1:0] req_msg_type;
    logic [5*NUM_REQ-1:0] req_number;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic                 inter_ready;
    logic                 transmit;
    logic                 ctrl_en;
    logic [2:0]           ctrl_msg_type;
    logic [4:0]           ctrl_number;

    modport master (
        input  req_valid, req_msg_type, req_number, inter_ready,
        output grant, done, err, transmit, ctrl_en,
        output ctrl_msg_type, ctrl_number
    );

    modport slave (
        output req_valid, req_msg_type, req_number, inter_ready,
        input  grant, done, err, transmit, ctrl_en,
        input  ctrl_msg_type, ctrl_number
    );
endinterface

// File: rtl/interboard_tx_scheduler.sv
// Round-robin scheduler sharing one interboard transmit channel between
// NUM_REQ requesters, with one message in flight, timeout and bounded retry.
// Ports:
//   clk            : system clock
//   rst            : asynchronous active-low reset
//   interboard_rst : synchronous link restart, aborts the transfer silently
//   bus            : requester and channel bundle (master modport)
//   busy           : high whenever the scheduler is not idle
module interboard_tx_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic interboard_rst,
    interboard_tx_scheduler_if.master bus,
    output logic busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_CMP,
        FINISH
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [IW-1:0] rr_ptr, rr_ptr_nx;
    logic [IW-1:0] pick, cand;
    logic          found;
    logic [TW-1:0] timer, timer_nx, tick;
    logic [2:0]    retries, retries_nx;
    logic          ok, ok_nx;
    logic          timeout;
    logic [2:0]    pay_type, pay_type_nx;
    logic [4:0]    pay_num, pay_num_nx;
    logic [NUM_REQ-1:0] sel_nx;
    logic [NUM_REQ-1:0] grant_r, done_r, err_r;
    logic          transmit_r;

    assign bus.grant         = grant_r;
    assign bus.done          = done_r;
    assign bus.err           = err_r;
    assign bus.transmit      = transmit_r;
    assign bus.ctrl_en       = transmit_r;
    assign bus.ctrl_msg_type = pay_type;
    assign bus.ctrl_number   = pay_num;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p,
                                           input int k);
        int j;
        j = int'(p) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        return IW'(j);
    endfunction

    // First requesting index after the last serviced one, with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = wrap(rr_ptr, k);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign timeout = (timer == TW'(TIMEOUT - 1));
    assign tick    = (timer == TW'(TIMEOUT)) ? timer : timer + TW'(1);

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        rr_ptr_nx   = rr_ptr;
        timer_nx    = timer;
        retries_nx  = retries;
        ok_nx       = ok;
        pay_type_nx = pay_type;
        pay_num_nx  = pay_num;
        unique case (state)
            IDLE: begin
                if (bus.inter_ready && found) begin
                    state_nx    = ISSUE;
                    idx_nx      = pick;
                    pay_type_nx = bus.req_msg_type[3*pick +: 3];
                    pay_num_nx  = bus.req_number[5*pick +: 5];
                    timer_nx    = '0;
                    retries_nx  = '0;
                    ok_nx       = 1'b0;
                end
            end
            ISSUE: begin
                state_nx = WAIT_ACC;
                timer_nx = '0;
            end
            WAIT_ACC, WAIT_CMP: begin
                if (state == WAIT_CMP && bus.inter_ready) begin
                    // completion beats a coincident timeout
                    state_nx = FINISH;
                    ok_nx    = 1'b1;
                end else if (timeout) begin
                    if (retries < 3'(MAX_RETRY)) begin
                        state_nx   = ISSUE;
                        retries_nx = retries + 3'd1;
                        timer_nx   = '0;
                    end else begin
                        state_nx = FINISH;
                        ok_nx    = 1'b0;
                    end
                end else begin
                    timer_nx = tick;
                    if (state == WAIT_ACC && !bus.inter_ready)
                        state_nx = WAIT_CMP;
                end
            end
            FINISH: begin
                state_nx  = IDLE;
                rr_ptr_nx = idx;
            end
            default: state_nx = IDLE;
        endcase
        // link restart: drop the transfer, keep pointer and payload
        if (interboard_rst) begin
            state_nx    = IDLE;
            idx_nx      = idx;
            rr_ptr_nx   = rr_ptr;
            timer_nx    = '0;
            retries_nx  = '0;
            pay_type_nx = pay_type;
            pay_num_nx  = pay_num;
        end
    end

    assign sel_nx = ONE << idx_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            rr_ptr     <= IW'(NUM_REQ - 1);
            timer      <= '0;
            retries    <= '0;
            ok         <= 1'b0;
            pay_type   <= '0;
            pay_num    <= '0;
            grant_r    <= '0;
            done_r     <= '0;
            err_r      <= '0;
            transmit_r <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            rr_ptr     <= rr_ptr_nx;
            timer      <= timer_nx;
            retries    <= retries_nx;
            ok         <= ok_nx;
            pay_type   <= pay_type_nx;
            pay_num    <= pay_num_nx;
            grant_r    <= (state_nx == ISSUE || state_nx == WAIT_ACC ||
                           state_nx == WAIT_CMP) ? sel_nx : '0;
            done_r     <= (state_nx == FINISH && ok_nx) ? sel_nx : '0;
            err_r      <= (state_nx == FINISH && !ok_nx) ? sel_nx : '0;
            transmit_r <= (state_nx == ISSUE);
            busy       <= (state_nx != IDLE);
        end
    end
endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Directed bench for interboard_tx_scheduler with a small channel model.
// Ports: none; drives the DUT through interboard_tx_scheduler_if.
module tb_interboard_tx_scheduler;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic interboard_rst = 1'b0;
    logic busy;

    interboard_tx_scheduler_if #(.NUM_REQ(N)) bus ();

    interboard_tx_scheduler #(
        .NUM_REQ(N),
        .TIMEOUT(16),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .interboard_rst(interboard_rst),
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int tx_gap = 0;
    int prev_tx_cyc = -1;
    int dbl = 0;
    int en_bad = 0;
    int mode = 0;
    int ign = 0;
    int drop_cd = 0;
    int rise_cd = 0;
    logic [2:0] first_type, last_type;
    logic [4:0] first_num, last_num;
    logic [N-1:0] tx_grant;
    logic [N-1:0] prev_grant, prev_done, prev_err;
    logic prev_tx;
    logic [N-1:0] done_q[$];
    logic [N-1:0] err_q[$];
    logic [N-1:0] grant_q[$];
    logic [N-1:0] rr_exp[4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        done_q.delete();
        err_q.delete();
        grant_q.delete();
        tx_cnt = 0;
        tx_gap = 0;
        prev_tx_cyc = -1;
    endtask

    task automatic wait_ev(input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() + err_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (done_q.size() + err_q.size() < n)
            chk("event_wait", done_q.size() + err_q.size(), n);
    endtask

    function automatic logic [31:0] qd(input int i);
        return (i < done_q.size()) ? 32'(done_q[i]) : 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] qg(input int i);
        return (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] qe(input int i);
        return (i < err_q.size()) ? 32'(err_q[i]) : 32'hffff_ffff;
    endfunction

    // Monitor plus channel: drops ready 2 cycles after an accepted
    // transmit and raises it again 10 cycles after that.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            bus.inter_ready = 1'b1;
            drop_cd = 0;
            rise_cd = 0;
            prev_tx = 1'b0;
            prev_grant = '0;
            prev_done = '0;
            prev_err = '0;
        end else begin
            cyc++;
            if (bus.transmit) begin
                if (tx_cnt == 0) begin
                    first_type = bus.ctrl_msg_type;
                    first_num = bus.ctrl_number;
                end
                tx_cnt++;
                last_type = bus.ctrl_msg_type;
                last_num = bus.ctrl_number;
                tx_grant = bus.grant;
                if (!bus.ctrl_en) en_bad++;
                if (prev_tx_cyc >= 0) tx_gap = cyc - prev_tx_cyc;
                prev_tx_cyc = cyc;
            end
            if (bus.transmit && prev_tx) dbl++;
            if (|(bus.done & prev_done)) dbl++;
            if (|(bus.err & prev_err)) dbl++;
            if ($countones(bus.grant) > 1) dbl++;
            if (bus.done != '0) done_q.push_back(bus.done);
            if (bus.err != '0) err_q.push_back(bus.err);
            if (bus.grant != '0 && bus.grant != prev_grant)
                grant_q.push_back(bus.grant);
            prev_tx = bus.transmit;
            prev_grant = bus.grant;
            prev_done = bus.done;
            prev_err = bus.err;
            if (bus.transmit) begin
                if (mode == 1 && ign > 0) ign--;
                else if (mode != 2) drop_cd = 2;
            end else if (drop_cd > 0) begin
                drop_cd--;
                if (drop_cd == 0) begin
                    bus.inter_ready = 1'b0;
                    rise_cd = 10;
                end
            end else if (rise_cd > 0) begin
                rise_cd--;
                if (rise_cd == 0) bus.inter_ready = 1'b1;
            end
        end
    end

    initial begin
        int k;
        rr_exp = '{'b001, 'b010, 'b100, 'b001};
        bus.req_valid = '0;
        bus.req_msg_type = {3'd7, 3'd2, 3'd5};
        bus.req_number = {5'd30, 5'd17, 5'd3};
        #3 rst = 1'b0;
        step();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_transmit", 32'(bus.transmit), 0);
        chk("rst_ctrl_en", 32'(bus.ctrl_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_type", 32'(bus.ctrl_msg_type), 0);
        chk("rst_number", 32'(bus.ctrl_number), 0);
        rst = 1'b1;
        step();
        step();

        // round robin from reset pointer
        clr();
        bus.req_valid = '1;
        wait_ev(4, 200);
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), qg(i), 32'(rr_exp[i]));
            chk($sformatf("rr_done%0d", i), qd(i), 32'(rr_exp[i]));
        end
        chk("rr_err_cnt", err_q.size(), 0);
        step();

        // single request
        clr();
        bus.req_valid = 'b010;
        wait_ev(1, 100);
        bus.req_valid = '0;
        chk("single_tx_cnt", tx_cnt, 1);
        chk("single_type", 32'(last_type), 2);
        chk("single_number", 32'(last_num), 17);
        chk("single_tx_grant", 32'(tx_grant), 'b010);
        chk("single_grant_cnt", grant_q.size(), 1);
        chk("single_done", qd(0), 'b010);
        chk("single_err_cnt", err_q.size(), 0);
        step();
        chk("single_busy", 32'(busy), 0);
        chk("single_grant_off", 32'(bus.grant), 0);

        // first transmit ignored, retried with same payload
        clr();
        mode = 1;
        ign = 1;
        bus.req_msg_type[8:6] = 3'd4;
        bus.req_number[14:10] = 5'd9;
        bus.req_valid = 'b100;
        k = 0;
        while (tx_cnt < 1 && k < 50) begin
            step();
            k++;
        end
        if (tx_cnt < 1) chk("retry_first_tx", tx_cnt, 1);
        bus.req_msg_type[8:6] = 3'd1;
        bus.req_number[14:10] = 5'd22;
        wait_ev(1, 150);
        bus.req_valid = '0;
        mode = 0;
        chk("retry_tx_cnt", tx_cnt, 2);
        chk("retry_gap", tx_gap, 17);
        chk("retry_first_type", 32'(first_type), 4);
        chk("retry_first_num", 32'(first_num), 9);
        chk("retry_last_type", 32'(last_type), 4);
        chk("retry_last_num", 32'(last_num), 9);
        chk("retry_grant_cnt", grant_q.size(), 1);
        chk("retry_done", qd(0), 'b100);
        chk("retry_err_cnt", err_q.size(), 0);
        step();

        // channel dead: all retries used, then next requester
        clr();
        mode = 2;
        bus.req_valid = 'b011;
        wait_ev(1, 200);
        mode = 0;
        chk("exh_tx_cnt", tx_cnt, 3);
        chk("exh_err", qe(0), 'b001);
        chk("exh_done_cnt", done_q.size(), 0);
        wait_ev(2, 100);
        bus.req_valid = '0;
        chk("exh_next_grant", qg(1), 'b010);
        chk("exh_next_done", qd(0), 'b010);
        chk("exh_err_cnt", err_q.size(), 1);
        step();

        // link restart while waiting for completion
        clr();
        bus.req_valid = 'b001;
        k = 0;
        while (bus.inter_ready !== 1'b0 && k < 50) begin
            step();
            k++;
        end
        if (bus.inter_ready !== 1'b0)
            chk("abort_accept", 32'(bus.inter_ready), 0);
        step();
        interboard_rst = 1'b1;
        step();
        interboard_rst = 1'b0;
        chk("abort_grant", 32'(bus.grant), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_transmit", 32'(bus.transmit), 0);
        step();
        step();
        step();
        chk("abort_hold_grant", 32'(bus.grant), 0);
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_no_err", err_q.size(), 0);
        wait_ev(1, 100);
        bus.req_valid = '0;
        chk("abort_reissue_tx", tx_cnt, 2);
        chk("abort_reissue_done", qd(0), 'b001);
        chk("abort_err_cnt", err_q.size(), 0);
        step();

        // async reset during issue
        clr();
        bus.req_valid = 'b101;
        k = 0;
        while (bus.transmit !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk("pre_rst_grant", 32'(bus.grant), 'b100);
        rst = 1'b0;
        #1;
        chk("async_transmit", 32'(bus.transmit), 0);
        chk("async_ctrl_en", 32'(bus.ctrl_en), 0);
        chk("async_grant", 32'(bus.grant), 0);
        step();
        step();
        clr();
        rst = 1'b1;
        wait_ev(1, 100);
        bus.req_valid = '0;
        chk("post_rst_grant", qg(0), 'b001);
        chk("post_rst_done", qd(0), 'b001);

        chk("pulse_width", dbl, 0);
        chk("ctrl_en_with_tx", en_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
